// File: rtl/cva6_rvfi_ser_pkg.sv
// Shared constants for the RVFI retirement serializer and a minimal default record type.
// The record type only needs a leading .valid flag for the serializer to work.
package cva6_rvfi_ser_pkg;

  localparam int unsigned ORDER_W    = 64;
  localparam int unsigned DROP_CNT_W = 32;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } rvfi_rec_min_t;

endpackage

// File: rtl/cva6_rvfi_ser_fifo.sv
// Circular buffer taking up to NrPorts compacted entries per cycle and releasing one.
// The caller guarantees wr_num never exceeds the free slots; Depth must be a power of two.
module cva6_rvfi_ser_fifo #(
  parameter int unsigned Depth   = 16,
  parameter int unsigned NrPorts = 2,
  parameter type         entry_t = logic,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = $clog2(Depth + 1),
  localparam int unsigned WnW    = $clog2(NrPorts + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [WnW-1:0]  wr_num,
  input  entry_t          wr_data [NrPorts],
  input  logic            pop,
  output entry_t          head,
  output logic [CntW-1:0] count
);

  entry_t          mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NrPorts; k++) begin
      if (k < int'(wr_num)) begin
        mem[wr_ptr + PtrW'(k)] <= wr_data[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PtrW'(wr_num);
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CntW'(wr_num) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/cva6_rvfi_serializer.sv
// Serializes per-commit-port RVFI records into a one-per-cycle valid/ready stream tagged
// with a 64-bit retirement order. Define CVA6_RVFI_SER_DROP_CNT_EN to get the drop counter.
module cva6_rvfi_serializer
  import cva6_rvfi_ser_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter type         rvfi_instr_t  = rvfi_rec_min_t,
  parameter int unsigned Depth         = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rvfi_instr_t           rvfi_i [NrCommitPorts],
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output rvfi_instr_t           rec_o,
  output logic [ORDER_W-1:0]    order_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned WnW  = $clog2(NrCommitPorts + 1);

  typedef struct packed {
    rvfi_instr_t        rec;
    logic [ORDER_W-1:0] order;
  } ser_entry_t;

  ser_entry_t         cmp [NrCommitPorts];
  ser_entry_t         head;
  logic [CntW-1:0]    count;
  logic [WnW-1:0]     n_wr;
  logic [ORDER_W-1:0] order_q;
  logic               overflow_q;
  logic               pop;
  int unsigned        n_push;
  int unsigned        free_slots;
  int unsigned        n_written;

  // Compaction: valid ports pack downward keeping port order; every valid record,
  // kept or dropped, consumes one order number so gaps reveal drops.
  always_comb begin
    n_push = 0;
    for (int unsigned k = 0; k < NrCommitPorts; k++) begin
      cmp[k] = '0;
    end
    for (int unsigned i = 0; i < NrCommitPorts; i++) begin
      if (rvfi_i[i].valid) begin
        for (int unsigned k = 0; k < NrCommitPorts; k++) begin
          if (n_push == k) begin
            cmp[k].rec   = rvfi_i[i];
            cmp[k].order = order_q + ORDER_W'(k);
          end
        end
        n_push = n_push + 1;
      end
    end
    // A same-cycle pop is deliberately not counted as free space.
    free_slots = Depth - 32'(count);
    n_written  = (n_push > free_slots) ? free_slots : n_push;
  end

  assign n_wr = WnW'(n_written);
  assign pop  = rec_valid_o && rec_ready_i;

  cva6_rvfi_ser_fifo #(
    .Depth   (Depth),
    .NrPorts (NrCommitPorts),
    .entry_t (ser_entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_num  (n_wr),
    .wr_data (cmp),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      order_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      order_q <= order_q + ORDER_W'(n_push);
      if (n_push > n_written) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef CVA6_RVFI_SER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input int unsigned b);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + (DROP_CNT_W + 1)'(b);
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (n_push > n_written) begin
      drop_cnt_q <= sat_add(drop_cnt_q, n_push - n_written);
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  // Head fields are masked while empty so stale storage never leaks out.
  assign rec_valid_o = (count != '0);
  assign rec_o       = rec_valid_o ? head.rec : '0;
  assign order_o     = rec_valid_o ? head.order : '0;
  assign full_o      = (count == CntW'(Depth));
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cva6_rvfi_serializer.sv
// Randomized bench for cva6_rvfi_serializer (2 commit ports, depth 4) against a queue model.
`timescale 1ns/1ps
module tb_cva6_rvfi_serializer;
  import cva6_rvfi_ser_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int OBS_W = 1 + $bits(rvfi_rec_min_t) + 64 + 1 + 1 + 32;
`ifdef CVA6_RVFI_SER_DROP_CNT_EN
  localparam int DC_EN = 1;
`else
  localparam int DC_EN = 0;
`endif

  typedef struct packed {
    rvfi_rec_min_t rec;
    logic [63:0]   order;
  } ment_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  rvfi_rec_min_t rvfi [NP];
  logic          rec_ready;
  logic          rec_valid;
  rvfi_rec_min_t rec;
  logic [63:0]   order;
  logic          full;
  logic          overflow;
  logic [31:0]   drop_cnt;

  always #5 clk = ~clk;

  cva6_rvfi_serializer #(
    .NrCommitPorts (NP),
    .rvfi_instr_t  (rvfi_rec_min_t),
    .Depth         (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rvfi_i      (rvfi),
    .rec_valid_o (rec_valid),
    .rec_ready_i (rec_ready),
    .rec_o       (rec),
    .order_o     (order),
    .full_o      (full),
    .overflow_o  (overflow),
    .drop_cnt_o  (drop_cnt)
  );

  // Reference model: a plain queue of (record, order) plus counters.
  ment_t             mq[$];
  logic [63:0]       m_order;
  bit                m_ovf;
  longint unsigned   m_drop;
  int                checks = 0;
  int                fails  = 0;

  function automatic logic [OBS_W-1:0] dut_obs();
    return {rec_valid, rec, order, full, overflow, drop_cnt};
  endfunction

  function automatic logic [OBS_W-1:0] model_exp();
    logic [31:0] dc;
    dc = (DC_EN != 0) ? 32'(m_drop) : 32'd0;
    if (mq.size() == 0)
      return {1'b0, {$bits(rvfi_rec_min_t){1'b0}}, 64'd0, 1'b0, m_ovf, dc};
    return {1'b1, mq[0].rec, mq[0].order, (mq.size() == DEPTH), m_ovf, dc};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_order = '0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_step();
    int free = DEPTH - mq.size();
    int idx  = 0;
    if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
    for (int p = 0; p < NP; p++) begin
      if (rvfi[p].valid) begin
        if (idx < free) begin
          mq.push_back('{rec: rvfi[p], order: m_order + 64'(idx)});
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 64'hFFFF_FFFF) m_drop++;
        end
        idx++;
      end
    end
    m_order = m_order + 64'(idx);
  endtask

  task automatic cycle(input bit v0, input bit v1, input bit rdy);
    rvfi[0]   = '{valid: v0, pc: $urandom, insn: $urandom};
    rvfi[1]   = '{valid: v1, pc: $urandom, insn: $urandom};
    rec_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rvfi[0]   = '0;
    rvfi[1]   = '0;
    rec_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rvfi[0]   = '0;
    rvfi[1]   = '0;
    rec_ready = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (dut_obs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs obs=%h exp=0", dut_obs());
    end
    rvfi[0]   = '{valid: 1'b1, pc: $urandom, insn: $urandom};
    rvfi[1]   = '{valid: 1'b1, pc: $urandom, insn: $urandom};
    rec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_obs() !== '0) begin
      fails++;
      $display("FAIL reset_hold obs=%h exp=0", dut_obs());
    end
    rvfi[0] = '0;
    rvfi[1] = '0;
    rst     = 1'b0;
    cycle(0, 0, 0);
    checks++;
    if (dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL reset_idle obs=%h exp=%h", dut_obs(), model_exp());
    end
  endtask

  task automatic test_single_pair();
    apply_reset();
    cycle(1, 1, 1);
    checks++;
    if (dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL pair_first obs=%h exp=%h", dut_obs(), model_exp());
    end
    checks++;
    if (order !== 64'd0 || rec_valid !== 1'b1) begin
      fails++;
      $display("FAIL pair_order0 valid=%b order=%0d exp valid=1 order=0", rec_valid, order);
    end
    cycle(0, 0, 1);
    checks++;
    if (order !== 64'd1 || rec_valid !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL pair_order1 valid=%b order=%0d ovf=%b exp 1/1/0", rec_valid, order, overflow);
    end
    cycle(0, 0, 1);
    checks++;
    if (dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL pair_empty obs=%h exp=%h", dut_obs(), model_exp());
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(1, 1, 0);
      checks++;
      if (dut_obs() !== model_exp()) begin
        fails++;
        $display("FAIL ovf_fill%0d obs=%h exp=%h", c, dut_obs(), model_exp());
      end
    end
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || drop_cnt !== 32'(2 * DC_EN)) begin
      fails++;
      $display("FAIL ovf_flags ovf=%b full=%b drop=%0d exp 1/1/%0d", overflow, full, drop_cnt,
               2 * DC_EN);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 1);
      checks++;
      if (dut_obs() !== model_exp()) begin
        fails++;
        $display("FAIL ovf_drain%0d obs=%h exp=%h", c, dut_obs(), model_exp());
      end
    end
    cycle(1, 0, 1);
    checks++;
    if (order !== 64'd6 || rec_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_next_order valid=%b order=%0d exp valid=1 order=6", rec_valid, order);
    end
  endtask

  task automatic test_pop_not_credited();
    int seen = 0;
    apply_reset();
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 1);
    checks++;
    if (dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL popnc_state obs=%h exp=%h", dut_obs(), model_exp());
    end
    checks++;
    if (overflow !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL popnc_flags ovf=%b full=%b exp 1/0", overflow, full);
    end
    for (int c = 0; c < 6; c++) begin
      if (rec_valid === 1'b1) seen++;
      cycle(0, 0, 1);
      checks++;
      if (dut_obs() !== model_exp()) begin
        fails++;
        $display("FAIL popnc_drain%0d obs=%h exp=%h", c, dut_obs(), model_exp());
      end
    end
    checks++;
    if (seen != 3) begin
      fails++;
      $display("FAIL popnc_count got=%0d exp=3", seen);
    end
  endtask

  task automatic test_port1_only();
    apply_reset();
    cycle(0, 1, 0);
    checks++;
    if (rec !== rvfi[1] || order !== 64'd0) begin
      fails++;
      $display("FAIL p1_first rec=%h order=%0d exp rec=%h order=0", rec, order, rvfi[1]);
    end
    cycle(0, 1, 1);
    checks++;
    if (order !== 64'd1 || dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL p1_second obs=%h exp=%h", dut_obs(), model_exp());
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    checks++;
    if (dut_obs() !== model_exp()) begin
      fails++;
      $display("FAIL mid_held obs=%h exp=%h", dut_obs(), model_exp());
    end
    rvfi[0] = '0;
    rvfi[1] = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rec_valid !== 1'b0 || dut_obs() !== '0) begin
      fails++;
      $display("FAIL mid_async obs=%h exp=0", dut_obs());
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 1);
    checks++;
    if (order !== 64'd0 || overflow !== 1'b0 || rec_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_after valid=%b order=%0d ovf=%b exp 1/0/0", rec_valid, order, overflow);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(1, 1, 1);
      checks++;
      if (dut_obs() !== model_exp()) begin
        fails++;
        $display("FAIL b2b%0d obs=%h exp=%h", c, dut_obs(), model_exp());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      checks++;
      if (dut_obs() !== model_exp()) begin
        fails++;
        $display("FAIL rand%0d obs=%h exp=%h", c, dut_obs(), model_exp());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_pair();
    test_overflow();
    test_pop_not_credited();
    test_port1_only();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
